// File: rtl/dcache_fill_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_fill_unit_pkg
// Brief    : Configuration types and helpers shared by the dcache fill path.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_fill_unit_pkg;

    // Data-cache portion of the CPU configuration.
    typedef struct packed {
        int unsigned WAYS;
    } dcache_config_t;

    // CPU configuration; only the data-cache fields are consumed here.
    typedef struct packed {
        dcache_config_t DCACHE;
    } cpu_config_t;

    localparam cpu_config_t EXAMPLE_CONFIG = '{DCACHE: '{WAYS: 2}};

    // Cache geometry derived from the CPU configuration.
    typedef struct packed {
        int unsigned LINE_ADDR_W;
        int unsigned SUB_LINE_ADDR_W;
        int unsigned TAG_W;
    } derived_cache_config_t;

    localparam int unsigned DATA_W = 32;

    // Clear the byte+word offset of an address so it points at the start of its line.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned offset_w);
        logic [31:0] mask;
        mask = (32'd1 << offset_w) - 32'd1;
        return addr & ~mask;
    endfunction

endpackage : dcache_fill_unit_pkg
`default_nettype wire

// File: rtl/dcache_fill_unit_way_cycler.sv
`default_nettype none
// ============================================================================
// Module   : way_cycler
// Brief    : One-hot round-robin victim pointer; rotates left on advance_i.
// Revision : 1.0 - initial release
// ============================================================================
module way_cycler #(
    parameter int WAYS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance_i,
    output logic [WAYS-1:0] way_o
);

    logic [WAYS-1:0] way_q;
    logic [WAYS-1:0] way_d;

    generate
        if (WAYS == 1) begin : g_single
            // A direct-mapped cache always evicts its only way.
            assign way_d = way_q | {1'b0, advance_i} | 1'b1;
        end else begin : g_multi
            // Rotate left by one, the top way wrapping back to way 0.
            assign way_d = advance_i ? {way_q[WAYS-2:0], way_q[WAYS-1]} : way_q;
        end
    endgenerate

    // Pointer register, restarting at way 0 on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            way_q <= WAYS'(1);
        end else begin
            way_q <= way_d;
        end
    end

    assign way_o = way_q;

endmodule : way_cycler
`default_nettype wire

// File: rtl/dcache_fill_unit.sv
`default_nettype none
// ============================================================================
// Module   : dcache_fill_unit
// Brief    : Data-cache line-fill controller. Fetches a missed line, streams
//            it into the data banks, forwards the requested word and installs
//            the new tag on the round-robin victim way.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_fill_unit
    import dcache_fill_unit_pkg::*;
#(
    parameter cpu_config_t           CONFIG  = EXAMPLE_CONFIG,
    parameter derived_cache_config_t SCONFIG = '{LINE_ADDR_W: 9, SUB_LINE_ADDR_W: 2, TAG_W: 15}
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    // Load pipe
    input  logic                                                    load_miss,
    input  logic [31:0]                                             load_addr_r,
    output logic                                                    busy,
    // Memory read channel
    output logic                                                    mem_rd_req,
    output logic [31:0]                                             mem_rd_addr,
    input  logic                                                    mem_rd_ack,
    input  logic                                                    mem_rd_data_valid,
    input  logic [31:0]                                             mem_rd_data,
    // Data banks
    output logic                                                    data_we,
    output logic [CONFIG.DCACHE.WAYS-1:0]                           data_way,
    output logic [SCONFIG.LINE_ADDR_W+SCONFIG.SUB_LINE_ADDR_W-1:0]  data_addr,
    output logic [31:0]                                             data_wdata,
    // Forwarded load word
    output logic                                                    load_data_valid,
    output logic [31:0]                                             load_data,
    // Tag-bank install (port A)
    output logic                                                    miss_req,
    output logic [31:0]                                             miss_addr,
    output logic [CONFIG.DCACHE.WAYS-1:0]                           miss_way
);

    localparam int WAYS     = int'(CONFIG.DCACHE.WAYS);
    localparam int LINE_W   = int'(SCONFIG.LINE_ADDR_W);
    localparam int SUB_W    = int'(SCONFIG.SUB_LINE_ADDR_W);
    localparam int OFFSET_W = SUB_W + 2;

    typedef logic [1:0] fill_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_TAG  = 2'd3;

    fill_state_t        state_q,     state_d;
    logic [31:0]        miss_addr_q, miss_addr_d;
    logic [WAYS-1:0]    miss_way_q,  miss_way_d;
    logic [SUB_W-1:0]   word_cnt_q,  word_cnt_d;

    logic [WAYS-1:0]    w_victim;
    logic               w_word_valid;
    logic               w_last_word;
    logic               w_req_word;

    way_cycler #(
        .WAYS (WAYS)
    ) u_way_cycler (
        .clk       (clk),
        .rst       (rst),
        .advance_i (state_q == ST_TAG),
        .way_o     (w_victim)
    );

    assign w_word_valid = (state_q == ST_FILL) && mem_rd_data_valid;
    assign w_last_word  = w_word_valid && (word_cnt_q == '1);
    assign w_req_word   = (word_cnt_q == miss_addr_q[OFFSET_W-1:2]);

    // Next-state logic: capture the miss, wait for ack, count words, install tag.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        miss_way_d  = miss_way_q;
        word_cnt_d  = word_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (load_miss) begin
                    miss_addr_d = load_addr_r;
                    miss_way_d  = w_victim;
                    word_cnt_d  = '0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_rd_ack) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_word_valid) begin
                    word_cnt_d = word_cnt_q + SUB_W'(1);
                end
                // The fill ends on the last word, never on counter overflow.
                if (w_last_word) begin
                    state_d = ST_TAG;
                end
            end
            ST_TAG: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and miss-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= '0;
            miss_way_q  <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            miss_way_q  <= miss_way_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign mem_rd_req      = (state_q == ST_REQ);
    assign mem_rd_addr     = line_base(miss_addr_q, OFFSET_W);

    // Returned words go straight to the banks with no added latency.
    assign data_we         = w_word_valid;
    assign data_way        = miss_way_q;
    assign data_addr       = {miss_addr_q[OFFSET_W +: LINE_W], word_cnt_q};
    assign data_wdata      = mem_rd_data;

    assign load_data_valid = w_word_valid && w_req_word;
    assign load_data       = mem_rd_data;

    assign miss_req        = (state_q == ST_TAG);
    assign miss_addr       = miss_addr_q;
    assign miss_way        = miss_way_q;

endmodule : dcache_fill_unit
`default_nettype wire

// File: tb/tb_dcache_fill_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_fill_unit
// Brief    : Self-checking bench for dcache_fill_unit (2 ways, 4-word lines,
//            9-bit line index).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_fill_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_miss;
    logic [31:0] load_addr_r;
    logic        busy;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ack;
    logic        mem_rd_data_valid;
    logic [31:0] mem_rd_data;
    logic        data_we;
    logic [1:0]  data_way;
    logic [10:0] data_addr;
    logic [31:0] data_wdata;
    logic        load_data_valid;
    logic [31:0] load_data;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic [1:0]  miss_way;

    always #5 clk = ~clk;

    dcache_fill_unit dut (
        .clk               (clk),
        .rst               (rst),
        .load_miss         (load_miss),
        .load_addr_r       (load_addr_r),
        .busy              (busy),
        .mem_rd_req        (mem_rd_req),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_ack        (mem_rd_ack),
        .mem_rd_data_valid (mem_rd_data_valid),
        .mem_rd_data       (mem_rd_data),
        .data_we           (data_we),
        .data_way          (data_way),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .load_data_valid   (load_data_valid),
        .load_data         (load_data),
        .miss_req          (miss_req),
        .miss_addr         (miss_addr),
        .miss_way          (miss_way)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    // Reference model state: fills completed since reset picks the victim way.
    int unsigned fills_done = 0;
    logic [31:0] line_words [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Model helpers written as address arithmetic on 16-byte lines.
    function automatic logic [31:0] m_line_base(input logic [31:0] a);
        return a - (a % 32'd16);
    endfunction

    // Bank word index: 9-bit line index (addr[12:4]) times 4 plus word number.
    function automatic logic [31:0] m_data_addr(input logic [31:0] a, input int k);
        return ((a / 32'd16) % 32'd512) * 32'd4 + 32'(k);
    endfunction

    function automatic int m_req_word(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd4);
    endfunction

    function automatic logic [31:0] m_victim();
        return 32'd1 << (fills_done % 2);
    endfunction

    // One complete miss. Called with the DUT idle, shortly after a falling edge.
    // gap_pat nibble k = idle cycles before word k; abort_after>0 resets after that many words.
    task automatic run_fill(input logic [31:0] addr, input int ack_dly, input int unsigned gap_pat,
                            input int abort_after, input bit fixed_words);
        logic [31:0] way_e;
        int          gap;
        way_e = m_victim();
        for (int k = 0; k < 4; k++) begin
            line_words[k] = fixed_words ? (32'hA0 + 32'(k)) : $urandom;
        end

        // Idle cycle: miss presented, stray data valid must not write.
        load_miss         = 1'b1;
        load_addr_r       = addr;
        mem_rd_data_valid = 1'b1;
        mem_rd_data       = $urandom;
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_we", 32'(data_we), 32'd0);
        chk("idle_ldv", 32'(load_data_valid), 32'd0);
        chk("idle_req", 32'(mem_rd_req), 32'd0);
        @(negedge clk);
        load_miss         = 1'b0;
        mem_rd_data_valid = 1'b0;

        // Request phase, ack on the last of ack_dly+1 cycles.
        for (int i = 0; i <= ack_dly; i++) begin
            mem_rd_ack = (i == ack_dly);
            #1;
            chk("req_req", 32'(mem_rd_req), 32'd1);
            chk("req_busy", 32'(busy), 32'd1);
            chk("req_addr", mem_rd_addr, m_line_base(addr));
            chk("req_we", 32'(data_we), 32'd0);
            @(negedge clk);
        end
        mem_rd_ack = 1'b0;

        // Fill phase; load_miss toggled here must be ignored.
        for (int k = 0; k < 4; k++) begin
            gap = int'((gap_pat >> (4 * k)) & 32'hF);
            for (int g = 0; g < gap; g++) begin
                mem_rd_data_valid = 1'b0;
                load_miss         = 1'b1;
                load_addr_r       = $urandom;
                #1;
                chk("gap_we", 32'(data_we), 32'd0);
                chk("gap_req", 32'(mem_rd_req), 32'd0);
                chk("gap_miss_req", 32'(miss_req), 32'd0);
                chk("gap_busy", 32'(busy), 32'd1);
                @(negedge clk);
            end
            mem_rd_data_valid = 1'b1;
            mem_rd_data       = line_words[k];
            load_miss         = 1'($urandom_range(0, 1));
            #1;
            chk("fill_we", 32'(data_we), 32'd1);
            chk("fill_way", 32'(data_way), way_e);
            chk("fill_addr", 32'(data_addr), m_data_addr(addr, k));
            chk("fill_wdata", data_wdata, line_words[k]);
            chk("fill_ldv", 32'(load_data_valid), 32'(k == m_req_word(addr)));
            if (k == m_req_word(addr)) begin
                chk("fill_ldata", load_data, line_words[m_req_word(addr)]);
            end
            chk("fill_req", 32'(mem_rd_req), 32'd0);
            chk("fill_miss_req", 32'(miss_req), 32'd0);
            @(negedge clk);
            mem_rd_data_valid = 1'b0;
            load_miss         = 1'b0;
            if (abort_after == k + 1) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_miss_req", 32'(miss_req), 32'd0);
                chk("abort_req", 32'(mem_rd_req), 32'd0);
                fills_done = 0;
                return;
            end
        end

        // Tag install cycle, then idle again.
        #1;
        chk("tag_miss_req", 32'(miss_req), 32'd1);
        chk("tag_miss_way", 32'(miss_way), way_e);
        chk("tag_miss_addr", miss_addr, addr);
        chk("tag_we", 32'(data_we), 32'd0);
        chk("tag_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_miss_req", 32'(miss_req), 32'd0);
        fills_done++;
    endtask

    initial begin
        rst               = 1'b1;
        load_miss         = 1'b0;
        load_addr_r       = '0;
        mem_rd_ack        = 1'b0;
        mem_rd_data_valid = 1'b0;
        mem_rd_data       = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(mem_rd_req), 32'd0);
        chk("rst_we", 32'(data_we), 32'd0);
        chk("rst_ldv", 32'(load_data_valid), 32'd0);
        chk("rst_miss_req", 32'(miss_req), 32'd0);
        chk("rst_miss_addr", miss_addr, 32'd0);
        chk("rst_miss_way", 32'(miss_way), 32'd0);

        // Basic fill: ack two cycles after the miss, words 0xA0..0xA3 back to back.
        run_fill(32'h0000_1238, 1, 32'h0, 0, 1'b1);
        // Round-robin: two more fills complete the 01,10,01 sequence.
        run_fill($urandom, 0, 32'h0, 0, 1'b0);
        run_fill($urandom, 1, 32'h0, 0, 1'b0);
        // Gapped data: words on cycles 1,3,4,7 after ack.
        run_fill($urandom, 0, 32'h0000_2010, 0, 1'b0);
        // Ack held off five cycles.
        run_fill($urandom, 5, 32'h0, 0, 1'b0);
        // Reset after two words, then the next fill restarts at way 0.
        run_fill($urandom, 0, 32'h0, 2, 1'b0);
        run_fill($urandom, 0, 32'h0, 0, 1'b0);

        // Randomized fills with random ack delays, gaps and occasional aborts.
        for (int n = 0; n < 16; n++) begin
            int unsigned gp;
            int          ab;
            gp = 0;
            for (int k = 0; k < 4; k++) begin
                gp = gp | (32'($urandom_range(0, 2)) << (4 * k));
            end
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_fill($urandom, int'($urandom_range(0, 3)), gp, ab, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dcache_fill_unit
`default_nettype wire
